// File: rtl/clk_gate_ctrl.sv
// ---------------------------------------------------------------------------
// clk_gate_ctrl
//
// Idle-detect controller for the enable pin of a GatedClk cell. It runs on the
// free-running clk and watches the activity of the gated domain. After
// IDLE_CYCLES consecutive idle cycles it drops enable. A wake request (req or
// force_on) restores enable, and ready follows once the gated clock has run
// for WAKE_CYCLES cycles.
//
// Parameters:
//   IDLE_CYCLES  consecutive idle cycles before gating (>= 1)
//   WAKE_CYCLES  cycles enable is high before ready asserts (>= 1)
//   STAT_W       width of the saturating gating-event counter
//
// Ports:
//   clk         free-running clock (same clock fed to GatedClk)
//   rst         synchronous reset, active-high
//   busy        gated-domain activity; 1 = must not gate
//   req         wake/work request, held until sampled with ready=1
//   force_on    debug override; blocks gating and forces a wake
//   enable      to GatedClk.enable; 1 = clock running
//   ready       gated clock stable; requester may proceed
//   gated       status: clock currently gated
//   gate_count  saturating count of RUN->GATED transitions
//
// All outputs are registered; no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module clk_gate_ctrl #(
  parameter int IDLE_CYCLES = 16,
  parameter int WAKE_CYCLES = 2,
  parameter int STAT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              busy,
  input  logic              req,
  input  logic              force_on,
  output logic              enable,
  output logic              ready,
  output logic              gated,
  output logic [STAT_W-1:0] gate_count
);

  // -------------------------------------------------------------------------
  // Parameter legality
  // -------------------------------------------------------------------------
  if (IDLE_CYCLES < 1) begin : g_idle_chk
    $error("clk_gate_ctrl: IDLE_CYCLES must be >= 1");
  end

  if (WAKE_CYCLES < 1) begin : g_wake_chk
    $error("clk_gate_ctrl: WAKE_CYCLES must be >= 1");
  end

  if (STAT_W < 1) begin : g_stat_chk
    $error("clk_gate_ctrl: STAT_W must be >= 1");
  end

  // -------------------------------------------------------------------------
  // Counter widths and terminal values
  // -------------------------------------------------------------------------
  // idle_cnt only ever reaches IDLE_CYCLES-1 before the transition clears
  // it, so it can never wrap.
  localparam int IW = $clog2(IDLE_CYCLES + 1);
  localparam int WW = $clog2(WAKE_CYCLES + 1);

  localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 1);
  localparam logic [WW-1:0] WAKE_LAST = WW'(WAKE_CYCLES - 1);

  // -------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------
  typedef enum logic [1:0] {
    RUN    = 2'd0,
    GATED  = 2'd1,
    WAKING = 2'd2
  } state_t;

  state_t          state;
  logic [IW-1:0]   idle_cnt;
  logic [WW-1:0]   wake_cnt;

  // Cycle qualifiers derived from the current inputs.
  logic            idle;
  logic            wake_req;
  logic            count_full;

  always_comb begin
    idle       = ~busy & ~req & ~force_on;
    wake_req   = req | force_on;
    count_full = &gate_count;
  end

  // -------------------------------------------------------------------------
  // Controller: state, counters and registered outputs in one process
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RUN;
      idle_cnt   <= '0;
      wake_cnt   <= '0;
      enable     <= 1'b1;
      ready      <= 1'b1;
      gated      <= 1'b0;
      gate_count <= '0;
    end else begin
      unique case (state)
        RUN: begin
          // req/force_on on the threshold cycle is activity, so only a truly
          // idle cycle can complete the run of idles.
          if (idle) begin
            if (idle_cnt == IDLE_LAST) begin
              state    <= GATED;
              idle_cnt <= '0;
              enable   <= 1'b0;
              ready    <= 1'b0;
              gated    <= 1'b1;
              if (!count_full) begin
                gate_count <= gate_count + STAT_W'(1);
              end
            end else begin
              idle_cnt <= idle_cnt + IW'(1);
            end
          end else begin
            idle_cnt <= '0;
          end
        end

        GATED: begin
          // busy is meaningless here: the gated domain is frozen. A req held
          // on the entry cycle is simply seen on the first GATED cycle.
          if (wake_req) begin
            state    <= WAKING;
            wake_cnt <= '0;
            enable   <= 1'b1;
            ready    <= 1'b0;
            gated    <= 1'b0;
          end
        end

        WAKING: begin
          // Fixed-length wake; no input can shorten or restart it.
          if (wake_cnt == WAKE_LAST) begin
            state    <= RUN;
            wake_cnt <= '0;
            idle_cnt <= '0;
            enable   <= 1'b1;
            ready    <= 1'b1;
            gated    <= 1'b0;
          end else begin
            wake_cnt <= wake_cnt + WW'(1);
          end
        end

        default: begin
          state    <= RUN;
          idle_cnt <= '0;
          wake_cnt <= '0;
          enable   <= 1'b1;
          ready    <= 1'b1;
          gated    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// ---------------------------------------------------------------------------
// tb_clk_gate_ctrl
//
// Directed bench for clk_gate_ctrl with IDLE_CYCLES=4, WAKE_CYCLES=2. Two
// instances share all inputs; the second uses STAT_W=2 so the saturating
// gate counter can be observed. The stimulus process pushes the hand-computed
// expected outputs for every clock edge into a queue; the monitor pops one
// entry per cycle on the falling edge and compares both instances.
// ---------------------------------------------------------------------------
module tb_clk_gate_ctrl;

  logic        clk;
  logic        rst;
  logic        busy;
  logic        req;
  logic        force_on;

  logic        enable;
  logic        ready;
  logic        gated;
  logic [15:0] gate_count;

  logic        enable2;
  logic        ready2;
  logic        gated2;
  logic [1:0]  gate_count2;

  typedef struct {
    logic        en;
    logic        rdy;
    logic        g;
    logic [15:0] c;
    logic [1:0]  c2;
    string       tag;
  } exp_t;

  exp_t exp_q[$];

  int unsigned checks = 0;
  int unsigned errors = 0;

  clk_gate_ctrl #(
    .IDLE_CYCLES(4),
    .WAKE_CYCLES(2),
    .STAT_W(16)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .busy       (busy),
    .req        (req),
    .force_on   (force_on),
    .enable     (enable),
    .ready      (ready),
    .gated      (gated),
    .gate_count (gate_count)
  );

  clk_gate_ctrl #(
    .IDLE_CYCLES(4),
    .WAKE_CYCLES(2),
    .STAT_W(2)
  ) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .busy       (busy),
    .req        (req),
    .force_on   (force_on),
    .enable     (enable2),
    .ready      (ready2),
    .gated      (gated2),
    .gate_count (gate_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs for one cycle, then record what both DUTs must show after
  // the edge that samples them.
  task automatic cyc(input logic r, input logic b, input logic q, input logic f,
                     input logic e_en, input logic e_rdy, input logic e_g,
                     input logic [15:0] e_c, input logic [1:0] e_c2,
                     input string tag);
    exp_t e;
    rst      = r;
    busy     = b;
    req      = q;
    force_on = f;
    @(posedge clk);
    e.en  = e_en;
    e.rdy = e_rdy;
    e.g   = e_g;
    e.c   = e_c;
    e.c2  = e_c2;
    e.tag = tag;
    exp_q.push_back(e);
    #1;
  endtask

  // n cycles with the given inputs where the block must stay in RUN.
  task automatic run_n(input int n, input logic b, input logic q, input logic f,
                       input logic [15:0] c, input logic [1:0] c2, input string tag);
    for (int i = 0; i < n; i++) cyc(1'b0, b, q, f, 1'b1, 1'b1, 1'b0, c, c2, tag);
  endtask

  // Wake with req (or force_on) held: enable next, ready two edges later,
  // then one more held cycle where the handshake is taken.
  task automatic wake(input logic use_force, input logic [15:0] c,
                      input logic [1:0] c2, input string tag);
    logic q;
    logic f;
    q = ~use_force;
    f = use_force;
    cyc(1'b0, 1'b0, q, f, 1'b1, 1'b0, 1'b0, c, c2, {tag, "_enable"});
    cyc(1'b0, 1'b0, q, f, 1'b1, 1'b0, 1'b0, c, c2, {tag, "_waking"});
    cyc(1'b0, 1'b0, q, f, 1'b1, 1'b1, 1'b0, c, c2, {tag, "_ready"});
    cyc(1'b0, 1'b0, q, f, 1'b1, 1'b1, 1'b0, c, c2, {tag, "_accept"});
  endtask

  // Monitor: one expectation per clock edge, checked on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if ({enable, ready, gated, gate_count, enable2, ready2, gated2, gate_count2} !==
            {e.en, e.rdy, e.g, e.c, e.en, e.rdy, e.g, e.c2}) begin
          errors++;
          $display("FAIL %s: got en=%b rdy=%b gated=%b cnt=%0d en2=%b rdy2=%b gated2=%b cnt2=%0d, want en=%b rdy=%b gated=%b cnt=%0d cnt2=%0d",
                   e.tag, enable, ready, gated, gate_count, enable2, ready2, gated2,
                   gate_count2, e.en, e.rdy, e.g, e.c, e.c2);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst      = 1'b1;
    busy     = 1'b0;
    req      = 1'b0;
    force_on = 1'b0;

    // Reset state, then the first cycle after release.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 2'd0, "reset");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 2'd0, "reset");
    run_n(1, 1'b0, 1'b0, 1'b0, 16'd0, 2'd0, "first_after_reset");

    // Four idle cycles gate the clock.
    run_n(2, 1'b0, 1'b0, 1'b0, 16'd0, 2'd0, "idle_run");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 2'd1, "gate_entry");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 2'd1, "gated_hold");
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 2'd1, "gated_busy_ignored");

    // req wake, then regate after four idles.
    wake(1'b0, 16'd1, 2'd1, "req_wake1");
    run_n(3, 1'b0, 1'b0, 1'b0, 16'd1, 2'd1, "idle_run2");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd2, 2'd2, "regate");
    wake(1'b0, 16'd2, 2'd2, "req_wake2");

    // A busy cycle breaks the run of idles.
    run_n(3, 1'b0, 1'b0, 1'b0, 16'd2, 2'd2, "idle3");
    run_n(1, 1'b1, 1'b0, 1'b0, 16'd2, 2'd2, "busy_break");
    run_n(3, 1'b0, 1'b0, 1'b0, 16'd2, 2'd2, "idle3_again");
    run_n(1, 1'b1, 1'b0, 1'b0, 16'd2, 2'd2, "busy_break2");

    // req on the threshold cycle is activity.
    run_n(3, 1'b0, 1'b0, 1'b0, 16'd2, 2'd2, "idle3_pre_req");
    run_n(1, 1'b0, 1'b1, 1'b0, 16'd2, 2'd2, "req_on_threshold");
    run_n(3, 1'b0, 1'b0, 1'b0, 16'd2, 2'd2, "idle3_post_req");
    run_n(1, 1'b1, 1'b0, 1'b0, 16'd2, 2'd2, "busy_break3");

    // force_on held blocks gating.
    run_n(50, 1'b0, 1'b0, 1'b1, 16'd2, 2'd2, "force_hold");
    run_n(3, 1'b0, 1'b0, 1'b0, 16'd2, 2'd2, "idle_after_force");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd3, 2'd3, "gate3");
    wake(1'b1, 16'd3, 2'd3, "force_wake");

    // Fourth and fifth gating: the 2-bit counter stays saturated.
    run_n(3, 1'b0, 1'b0, 1'b0, 16'd3, 2'd3, "idle_run4");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd4, 2'd3, "gate4_sat");
    wake(1'b0, 16'd4, 2'd3, "req_wake4");
    run_n(3, 1'b0, 1'b0, 1'b0, 16'd4, 2'd3, "idle_run5");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd5, 2'd3, "gate5_sat");

    // Reset on the first WAKING cycle.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'd5, 2'd3, "wake5_enable");
    cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 2'd0, "reset_in_waking");
    run_n(1, 1'b0, 1'b1, 1'b0, 16'd0, 2'd0, "accept_after_reset");

    // Reset while GATED.
    run_n(3, 1'b0, 1'b0, 1'b0, 16'd0, 2'd0, "idle_run6");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 2'd1, "gate6");
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd1, 2'd1, "gated_hold6");
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 16'd0, 2'd0, "reset_in_gated");
    run_n(1, 1'b0, 1'b0, 1'b0, 16'd0, 2'd0, "run_after_gated_reset");

    // Let the monitor drain, bounded.
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/clk_gate_ctrl.md
Name: clk_gate_ctrl

Overview:
- Idle-detect controller that drives the `enable` input of the GatedClk cell.
- Watches activity of the clock-gated logic and drops `enable` after a programmable run of idle cycles.
- Restores `enable` on a wake request, then asserts `ready` once the gated clock has been stable for a fixed number of cycles.
- Lives in the ungated (free-running) `clk` domain, directly upstream of GatedClk.

Parameters:
IDLE_CYCLES, 16, consecutive idle cycles required before gating; elaboration error if < 1
WAKE_CYCLES, 2, cycles `enable` is high before `ready` asserts; elaboration error if < 1
STAT_W, 16, width of the gating-event counter

Ports:
clk  input  1  free-running clock (same clk fed to GatedClk)
rst  input  1  synchronous reset, active-high
busy  input  1  gated-domain activity; 1 = must not gate
req  input  1  wake/work request; held by requester until sampled with ready=1
force_on  input  1  debug override; prevents gating and forces wake
enable  output  1  to GatedClk.enable; 1 = clock running
ready  output  1  gated clock stable; requester may proceed
gated  output  1  status: clock currently gated
gate_count  output  STAT_W  saturating count of RUN->GATED transitions

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-high.
- All outputs are registered.
- Reset:
  - state=RUN; enable=1, ready=1, gated=0, gate_count=0.
  - Idle and wake counters are cleared.
  - The clock runs during reset so the gated logic can itself be reset.
  - Assertion in any state returns to RUN on the next edge, including mid-WAKING and mid-GATED.
- idle = ~busy & ~req & ~force_on.
- RUN: enable=1, ready=1, gated=0.
  - idle_cnt increments on each idle cycle and clears to 0 on any non-idle cycle.
  - On an idle cycle with idle_cnt == IDLE_CYCLES-1, go to GATED.
  - enable drops at the edge after the IDLE_CYCLES-th consecutive idle cycle.
  - idle_cnt width is clog2(IDLE_CYCLES+1). It must never wrap: it stops at the threshold.
- GATED: enable=0, ready=0, gated=1.
  - gate_count increments by 1 on entry and saturates at all-ones.
  - busy is ignored in this state, since the gated domain is frozen.
  - On req=1 or force_on=1, go to WAKING: enable=1 from the next edge, gated=0.
- WAKING: enable=1, ready=0, gated=0.
  - wake_cnt counts from 0. After WAKING has lasted WAKE_CYCLES cycles, go to RUN with ready=1.
  - busy, req and force_on do not shorten or restart the wake.
- Wake latency: if req is sampled high in GATED at edge N, then enable=1 after edge N and ready=1 after edge N+WAKE_CYCLES.
- Handshake:
  - A request is accepted when req=1 and ready=1 in the same cycle.
  - The requester holds req until then; the block never drops a held req.
  - req is not stored internally.
- Simultaneous events:
  - In RUN, req or force_on on the threshold cycle counts as activity: stay in RUN and clear idle_cnt.
  - On the cycle GATED is entered, req is not sampled for wake. It is sampled on the first GATED cycle.
- force_on held high: the block never enters GATED. If asserted in GATED, it wakes exactly as req does.
- No combinational path from any input to any output.

Test Plan:
- Reset with IDLE_CYCLES=4, WAKE_CYCLES=2 -> enable=1, ready=1, gated=0, gate_count=0 while rst=1 and on the first cycle after release.
- Drive idle for 4 cycles after reset -> enable=0, gated=1 on the 5th cycle; gate_count=1. Drive idle 3 cycles, busy 1, idle 3 -> enable stays 1 throughout.
- In GATED, pulse req high and hold it -> enable=1 on the next cycle; ready=1 two cycles later; req dropped after the ready=1 sample; then 4 idle cycles regate, gate_count=2.
- force_on=1 held for 50 idle cycles -> enable never drops. force_on asserted in GATED -> same wake timing as req.
- rst asserted on the 1st WAKING cycle -> next cycle RUN: enable=1, ready=1, gate_count=0.
- STAT_W=2 with 5 gate/wake loops -> gate_count reads 1, 2, 3, 3, 3 (saturates).
